// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite RAM: response codes, FSM states, and the write request.
package axi_lite_pkg;
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int DATA_W    = NUM_LANES * VEC_W;
  localparam int ADDR_W    = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]                 addr;
    logic [NUM_LANES-1:0][VEC_W-1:0]   data;
    logic [NUM_LANES-1:0]              strb;
  } wr_req_t;
endpackage

// File: rtl/axi_lite_ram_array.sv
// Word storage split into byte lanes: per-lane write enable, registered read port.
// Storage is never reset; only the read register has a synchronous clear.
module axi_lite_ram_array
  import axi_lite_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [IDX_W-1:0]                 widx,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]  wdata,
  input  logic [NUM_LANES-1:0]             wstrb,
  input  logic                             re,
  input  logic                             rclr,
  input  logic [IDX_W-1:0]                 ridx,
  output logic [NUM_LANES-1:0][VEC_W-1:0]  rdata
);
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [VEC_W-1:0] mem [DEPTH_WORDS];
    logic [VEC_W-1:0] lane_q;

    always_ff @(posedge clk) begin
      if (we && wstrb[l]) mem[widx] <= wdata[l];
    end

    // Read-before-write: a same-edge read sees the old contents.
    always_ff @(posedge clk) begin
      if (rclr)    lane_q <= '0;
      else if (re) lane_q <= mem[ridx];
    end

    assign rdata[l] = lane_q;
  end
endmodule

// File: rtl/axi_lite_ram.sv
// AXI4-Lite responder over a byte-lane RAM with independent read and write FSMs.
// Optional AXI_LITE_RAM_RANGE_CHECK_EN: out-of-window accesses get SLVERR; otherwise index wraps.
module axi_lite_ram
  import axi_lite_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddress,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddress,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // ---------------- write channel ----------------
  w_state_e w_state, w_state_d;
  wr_req_t  req_q, req_eff;
  logic     aw_held, aw_held_d, w_held, w_held_d;
  logic     awready_d, wready_d, bvalid_d;
  resp_e    bresp_q, bresp_d;
  logic     aw_hs, w_hs, commit, w_ok, mem_we;
  logic [31:0] w_off;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // Merge held beats with beats handshaking this edge so same-cycle AW+W commit at once.
  always_comb begin
    req_eff = req_q;
    if (aw_hs) req_eff.addr = awaddress;
    if (w_hs) begin
      req_eff.data = wdata;
      req_eff.strb = wstrb;
    end
  end

  assign w_off  = req_eff.addr - BASE_ADDR;
  assign commit = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
`ifdef AXI_LITE_RAM_RANGE_CHECK_EN
  assign w_ok   = (w_off[31:IDX_W+2] == '0);
`else
  assign w_ok   = 1'b1;
`endif
  assign mem_we = commit & w_ok & ~reset;

  always_comb begin
    w_state_d = w_state;
    awready_d = awready;
    wready_d  = wready;
    bvalid_d  = bvalid;
    bresp_d   = bresp_q;
    aw_held_d = aw_held;
    w_held_d  = w_held;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) begin aw_held_d = 1'b1; awready_d = 1'b0; end
        if (w_hs)  begin w_held_d  = 1'b1; wready_d  = 1'b0; end
        if (commit) begin
          w_state_d = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = w_ok ? OKAY : SLVERR;
        end
      end
      W_RESP: begin
        if (bvalid && bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b1;
      bvalid  <= 1'b0;
      bresp_q <= OKAY;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      w_state <= w_state_d;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
      bresp_q <= bresp_d;
      aw_held <= aw_held_d;
      w_held  <= w_held_d;
    end
  end

  // Payload needs no reset: the held flags decide whether it is live.
  always_ff @(posedge clk) req_q <= req_eff;

  assign bresp = bresp_q;

  // ---------------- read channel ----------------
  r_state_e r_state, r_state_d;
  logic     arready_d, rvalid_d, ar_hs, r_ok, rd_en, rd_clr;
  resp_e    rresp_q, rresp_d;
  logic [31:0] r_off;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_q;

  assign ar_hs = arvalid & arready;
  assign r_off = araddress - BASE_ADDR;
`ifdef AXI_LITE_RAM_RANGE_CHECK_EN
  assign r_ok  = (r_off[31:IDX_W+2] == '0);
`else
  assign r_ok  = 1'b1;
`endif
  assign rd_en  = ar_hs & r_ok & ~reset;
  assign rd_clr = reset | (ar_hs & ~r_ok);

  always_comb begin
    r_state_d = r_state;
    arready_d = arready;
    rvalid_d  = rvalid;
    rresp_d   = rresp_q;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = r_ok ? OKAY : SLVERR;
        end
      end
      R_DATA: begin
        if (rvalid && rready) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rresp_q <= OKAY;
    end else begin
      r_state <= r_state_d;
      arready <= arready_d;
      rvalid  <= rvalid_d;
      rresp_q <= rresp_d;
    end
  end

  assign rresp = rresp_q;
  assign rdata = rd_q;

  axi_lite_ram_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .widx  (w_off[IDX_W+1:2]),
    .wdata (req_eff.data),
    .wstrb (req_eff.strb),
    .re    (rd_en),
    .rclr  (rd_clr),
    .ridx  (r_off[IDX_W+1:2]),
    .rdata (rd_q)
  );

  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, w_off[31:IDX_W+2], w_off[1:0],
                       r_off[31:IDX_W+2], r_off[1:0]};
endmodule

// File: tb/tb_axi_lite_ram.sv
// Directed bench for axi_lite_ram: stimulus pushes expected B/R responses, a monitor pops and checks.
module tb_axi_lite_ram;
  logic        clk = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddress, wdata, araddress, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0]  b_q[$];
  logic [33:0] r_q[$];

  always #5 clk = ~clk;

  axi_lite_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddress(awaddress), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one pop per handshake, sampled on the falling edge before it completes.
  always @(negedge clk) begin
    if (!reset && bvalid && bready) begin
      if (b_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_b: got bresp %0h expected none", bresp);
      end else chk("bresp", bresp, b_q.pop_front());
    end
    if (!reset && rvalid && rready) begin
      if (r_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_r: got rdata %0h expected none", rdata);
      end else chk("rresp_rdata", {rresp, rdata}, r_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_aw(input logic [31:0] a);
    int n = 0; logic hs = 1'b0;
    awaddress = a; awvalid = 1'b1;
    while (!hs && n < 20) begin @(posedge clk); hs = awready; n++; end
    #1 awvalid = 1'b0;
    if (!hs) chk("aw_timeout", 0, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0; logic hs = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!hs && n < 20) begin @(posedge clk); hs = wready; n++; end
    #1 wvalid = 1'b0;
    if (!hs) chk("w_timeout", 0, 1);
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0; logic hs = 1'b0;
    araddress = a; arvalid = 1'b1;
    while (!hs && n < 20) begin @(posedge clk); hs = arready; n++; end
    #1 arvalid = 1'b0;
    if (!hs) chk("ar_timeout", 0, 1);
  endtask

  task automatic wait_b();
    int n = 0;
    while (bvalid && n < 20) begin tick(); n++; end
    if (bvalid) chk("b_drain_timeout", 0, 1);
  endtask

  task automatic wait_r();
    int n = 0;
    while (rvalid && n < 20) begin tick(); n++; end
    if (rvalid) chk("r_drain_timeout", 0, 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] resp);
    b_q.push_back(resp);
    fork
      send_aw(a);
      send_w(d, s);
    join
    wait_b();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    r_q.push_back({resp, d});
    send_ar(a);
    wait_r();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddress = 0; wdata = 0; wstrb = 0; araddress = 0; awprot = 3'b010; arprot = 3'b101;
    tick(); tick();
    chk("rst_awready", awready, 1);
    chk("rst_wready",  wready,  1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid",  bvalid,  0);
    chk("rst_rvalid",  rvalid,  0);
    chk("rst_resp",    {bresp, rresp}, 0);
    chk("rst_rdata",   rdata,   0);
    reset = 1'b0;
    tick();

    // AW and W together; B one cycle later, then read back with 1-cycle latency.
    b_q.push_back(2'b00);
    fork
      send_aw(32'h10);
      send_w(32'hDEAD_BEEF, 4'hF);
    join
    chk("b_latency", bvalid, 1);
    wait_b();
    r_q.push_back({2'b00, 32'hDEAD_BEEF});
    send_ar(32'h10);
    chk("r_latency", rvalid, 1);
    wait_r();

    // W leads AW by three cycles; single byte lane.
    send_w(32'h0000_00AA, 4'b0001);
    chk("w_only_no_commit", bvalid, 0);
    chk("w_only_awready", {awready, wready}, 2'b10);
    tick(); tick();
    chk("w_wait_no_commit", bvalid, 0);
    b_q.push_back(2'b00);
    send_aw(32'h10);
    chk("late_aw_b", bvalid, 1);
    wait_b();
    do_read(32'h10, 32'hDEAD_BEAA, 2'b00);

    // B backpressure: response stable, second AW blocked until B handshake.
    bready = 1'b0;
    b_q.push_back(2'b00);
    fork
      send_aw(32'h20);
      send_w(32'h0000_0055, 4'hF);
    join
    awaddress = 32'h24; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid",  bvalid,  1);
      chk("bp_bresp",   bresp,   0);
      chk("bp_awready", awready, 0);
      tick();
    end
    bready = 1'b1;
    tick();
    chk("bp_b_done",  bvalid,  0);
    chk("bp_aw_open", awready, 1);
    tick();
    awvalid = 1'b0;
    chk("bp_aw_taken", awready, 0);
    b_q.push_back(2'b00);
    send_w(32'h0000_0066, 4'hF);
    wait_b();
    do_read(32'h20, 32'h0000_0055, 2'b00);
    do_read(32'h24, 32'h0000_0066, 2'b00);

    // Same-edge read and write to one word: read sees the old value.
    r_q.push_back({2'b00, 32'hDEAD_BEAA});
    b_q.push_back(2'b00);
    fork
      send_ar(32'h10);
      send_aw(32'h10);
      send_w(32'h1122_3344, 4'hF);
    join
    wait_b();
    wait_r();
    do_read(32'h10, 32'h1122_3344, 2'b00);
    do_read(32'h13, 32'h1122_3344, 2'b00);

    // Out-of-window address.
    do_write(32'h0, 32'h0102_0304, 4'hF, 2'b00);
`ifdef AXI_LITE_RAM_RANGE_CHECK_EN
    do_write(32'h1000, 32'hCAFE_F00D, 4'hF, 2'b10);
    do_read(32'h0,    32'h0102_0304, 2'b00);
    do_read(32'h1000, 32'h0,         2'b10);
`else
    do_write(32'h1000, 32'hCAFE_F00D, 4'hF, 2'b00);
    do_read(32'h0,    32'hCAFE_F00D, 2'b00);
    do_read(32'h1000, 32'hCAFE_F00D, 2'b00);
`endif

    // Zero strobes leave storage alone.
    do_write(32'h20, 32'hFFFF_FFFF, 4'h0, 2'b00);
    do_read(32'h20, 32'h0000_0055, 2'b00);

    // Reset in R_DATA and after AW-only capture aborts both.
    do_write(32'h30, 32'h0000_0077, 4'hF, 2'b00);
    rready = 1'b0;
    fork
      send_ar(32'h24);
      send_aw(32'h30);
    join
    chk("pre_rst_rvalid", rvalid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_rvalid",  rvalid, 0);
    chk("abort_readies", {awready, wready, arready}, 3'b111);
    chk("abort_bvalid",  bvalid, 0);
    chk("abort_rdata",   rdata,  0);
    rready = 1'b1;
    send_w(32'hBADB_AD00, 4'hF);
    tick(); tick(); tick();
    chk("abort_no_commit", bvalid, 0);
    b_q.push_back(2'b00);
    send_aw(32'h34);
    wait_b();
    do_read(32'h30, 32'h0000_0077, 2'b00);
    do_read(32'h34, 32'hBADB_AD00, 2'b00);

    tick();
    chk("b_queue_empty", b_q.size(), 0);
    chk("r_queue_empty", r_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_ram.md
AXI_LITE_RAM -- requirements
Module: axi_lite_ram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two, at least 2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address mapped to word 0.
REQ-003 SHALL have ports:
  clk  input  1  sole clock; all logic on its rising edge.
  reset  input  1  synchronous, active-high reset.
  awvalid  input  1  write address valid.
  awready  output  1  write address ready.
  awaddress  input  32  write byte address.
  awprot  input  3  protection; accepted and ignored.
  wvalid  input  1  write data valid.
  wready  output  1  write data ready.
  wdata  input  32  write data.
  wstrb  input  4  byte enables; bit n gates wdata[8n+7:8n].
  bvalid  output  1  write response valid.
  bready  input  1  write response ready.
  bresp  output  2  write response code.
  arvalid  input  1  read address valid.
  arready  output  1  read address ready.
  araddress  input  32  read byte address.
  arprot  input  3  protection; accepted and ignored.
  rvalid  output  1  read data valid.
  rready  input  1  read data ready.
  rdata  output  32  read data.
  rresp  output  2  read response code.

Function
REQ-004 SHALL act as an AXI4-Lite responder with independent read and write state machines and all outputs registered.
REQ-005 Word index SHALL be (address - BASE_ADDR) >> 2; address bits [1:0] SHALL be ignored (no misalignment error).
REQ-006 Write FSM SHALL have states W_IDLE, W_RESP. In W_IDLE, awready and wready SHALL each be high until their own channel handshakes; AW and W SHALL be captured independently, in either order or in the same cycle.
REQ-007 The write SHALL commit on the first edge at which both AW and W are held. At that edge the FSM SHALL enter W_RESP, deassert awready and wready, and assert bvalid.
REQ-008 In W_RESP, bvalid and bresp SHALL hold stable until bvalid && bready. On the next edge the FSM SHALL return to W_IDLE with awready=1 and wready=1.
REQ-009 Read FSM SHALL have states R_IDLE, R_DATA. In R_IDLE, arready=1. On arvalid && arready, the block SHALL register rdata from storage, assert rvalid on the next cycle (1-cycle latency), deassert arready, and enter R_DATA.
REQ-010 In R_DATA, rvalid, rdata and rresp SHALL hold stable until rvalid && rready. On the next edge the FSM SHALL return to R_IDLE.
REQ-011 When a read handshake and a write commit to the same word occur on the same edge, the read SHALL return the pre-write data.
REQ-012 A write with wstrb=4'b0000 SHALL leave storage unchanged and respond OKAY.
REQ-013 Valid/ready dependence: the block SHALL NOT wait for bready or rready before raising bvalid or rvalid.

Reset
REQ-014 While reset=1 at an edge, the block SHALL set awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00 and rdata=0, and return both FSMs to idle.
REQ-015 Reset mid-transaction SHALL abort the transaction: captured AW/W/AR SHALL be discarded and no storage write SHALL occur for an uncommitted write. Storage contents SHALL NOT be reset.

Configuration
REQ-016 With AXI_LITE_RAM_RANGE_CHECK_EN defined, an address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) SHALL get response SLVERR (2'b10), writes to it SHALL be dropped, and reads from it SHALL return rdata=0.
REQ-017 Without AXI_LITE_RAM_RANGE_CHECK_EN, the word index SHALL wrap modulo DEPTH_WORDS, and every response SHALL be OKAY (2'b00).

Structure
REQ-018 Package axi_lite_pkg SHALL hold the response enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and the write-FSM and read-FSM state typedefs.
REQ-019 Storage SHALL be the sub-module axi_lite_ram_array: one synchronous read port, one write port with per-byte enable, and no reset.

Verification
REQ-020 AW and W in the same cycle, addr 0x10, data 0xDEADBEEF, wstrb 4'hF -> bvalid the next cycle, bresp=OKAY; then read of 0x10 -> rvalid one cycle after AR, rdata=0xDEADBEEF.
REQ-021 W three cycles before AW, addr 0x10, data 0x000000AA, wstrb 4'b0001 -> single commit after AW; read of 0x10 returns 0xDEADBE AA (0xDEADBEAA).
REQ-022 bready held low 5 cycles -> bvalid and bresp stable for all 5 cycles; awready=0 throughout; a second AW is accepted only after the B handshake.
REQ-023 Read of 0x10 and write of 0x11223344 to 0x10 committing on the same edge -> read returns the old value and a subsequent read returns 0x11223344.
REQ-024 Range check with DEPTH_WORDS=1024 and BASE_ADDR=0, write to 0x1000 -> with the macro: bresp=SLVERR, word 0 unchanged, read rdata=0 with rresp=SLVERR; without the macro: write lands in word 0, resp=OKAY.
REQ-025 Reset asserted in R_DATA with rvalid=1 and in the cycle after AW-only capture -> next cycle rvalid=0 and all readies=1; a following W-only handshake SHALL NOT commit a write.
